// File: rtl/scaler_v.sv
// rtl/scaler_v.sv - vertical down-scaler: one line buffer, per-line emit/drop, 3-stage interpolation
module scaler_v #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int PIXEL_STEP     = 128,
    parameter int COE_WIDTH      = 8,
    parameter int MAX_LINE_WIDTH = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            scale_step_v,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int SHIFT = $clog2(PIXEL_STEP);
    localparam int AW    = (MAX_LINE_WIDTH > 1) ? $clog2(MAX_LINE_WIDTH) : 1;
    localparam int XW    = AW + 1;
    localparam int MW    = PIXEL_WIDTH + COE_WIDTH + 1;
    localparam logic [15:0]    STEP16 = 16'(PIXEL_STEP);
    localparam logic [16:0]    STEP17 = 17'(PIXEL_STEP);
    localparam logic [COE_WIDTH:0] STEPC = (COE_WIDTH + 1)'(PIXEL_STEP);
    localparam logic [XW-1:0]  XMAX   = XW'(MAX_LINE_WIDTH);
    localparam logic [MW-1:0]  HALF   = MW'(PIXEL_STEP / 2);

    // frame / line state
    logic                 vs_q;
    logic [15:0]          step_r;
    logic [1:0]           line_cnt;
    logic [16:0]          pos;
    logic                 emit_line;
    logic [COE_WIDTH-1:0] f_line;
    logic [XW-1:0]        x_cnt;

    // decision for the current cycle
    logic                 frame_start;
    logic [15:0]          step_cur;
    logic [1:0]           lc_cur;
    logic [16:0]          pos_cur;
    logic                 emit_dec;
    logic [16:0]          pos_dec;
    logic                 emit_now;
    logic [COE_WIDTH-1:0] f_now;
    logic [XW-1:0]        x_now;
    logic                 x_ok;
    logic                 wr;

    always_comb begin
        frame_start = vs_i & ~vs_q;
        step_cur    = step_r;
        lc_cur      = line_cnt;
        pos_cur     = pos;
        if (frame_start) begin
            step_cur = (scale_step_v > STEP16) ? scale_step_v : STEP16;
            lc_cur   = 2'd0;
            pos_cur  = 17'd0;
        end
        emit_dec = 1'b0;
        pos_dec  = pos_cur;
        if (lc_cur != 2'd0) begin
            if (pos_cur < STEP17) begin
                emit_dec = 1'b1;
                pos_dec  = pos_cur + {1'b0, step_cur} - STEP17;
            end else begin
                pos_dec  = pos_cur - STEP17;
            end
        end
        // a pixel arriving with hs_i already belongs to the new line at index 0
        emit_now = hs_i ? emit_dec : emit_line;
        f_now    = hs_i ? pos_cur[COE_WIDTH-1:0] : f_line;
        x_now    = hs_i ? '0 : x_cnt;
        x_ok     = x_now < XMAX;
        wr       = de_i & x_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // high so that vs_i already high at release is not seen as a frame start
            vs_q      <= 1'b1;
            step_r    <= STEP16;
            line_cnt  <= 2'd0;
            pos       <= 17'd0;
            emit_line <= 1'b0;
            f_line    <= '0;
            x_cnt     <= '0;
        end else begin
            vs_q   <= vs_i;
            step_r <= step_cur;
            if (hs_i) begin
                line_cnt  <= (lc_cur == 2'd2) ? 2'd2 : lc_cur + 2'd1;
                pos       <= pos_dec;
                emit_line <= emit_dec;
                f_line    <= pos_cur[COE_WIDTH-1:0];
            end else begin
                line_cnt  <= lc_cur;
                pos       <= pos_cur;
            end
            if (de_i) begin
                x_cnt <= x_ok ? x_now + XW'(1) : x_now;
            end else if (hs_i) begin
                x_cnt <= '0;
            end
        end
    end

    // line buffer, read-before-write; its output register is pipeline stage 1
    logic [PIXEL_WIDTH-1:0] mem [MAX_LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0] prev_s1;

    always_ff @(posedge clk) begin
        if (wr) begin
            prev_s1            <= mem[x_now[AW-1:0]];
            mem[x_now[AW-1:0]] <= di_i;
        end
    end

    logic                   s1_de, s1_hs, s1_vs;
    logic [PIXEL_WIDTH-1:0] s1_cur;
    logic [COE_WIDTH-1:0]   s1_f;
    logic                   s2_de, s2_hs, s2_vs;
    logic [MW-1:0]          s2_p0, s2_p1;
    logic [COE_WIDTH:0]     wt0;
    logic [MW-1:0]          sum_s2;

    always_comb begin
        wt0    = STEPC - {1'b0, s1_f};
        sum_s2 = s2_p0 + s2_p1 + HALF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_de  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_cur <= '0;
            s1_f   <= '0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_p0  <= '0;
            s2_p1  <= '0;
            do_o   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
        end else begin
            s1_de  <= wr & emit_now;
            s1_hs  <= hs_i & emit_now;
            s1_vs  <= vs_i;
            s1_cur <= di_i;
            s1_f   <= f_now;
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_p0  <= MW'(prev_s1) * MW'(wt0);
            s2_p1  <= MW'(s1_cur) * MW'(s1_f);
            if (s2_de) begin
                do_o <= PIXEL_WIDTH'(sum_s2 >> SHIFT);
            end
            de_o   <= s2_de;
            hs_o   <= s2_hs;
            vs_o   <= s2_vs;
        end
    end

endmodule

// File: tb/tb_scaler_v.sv
// tb/tb_scaler_v.sv - self-checking bench for scaler_v against a line-level reference model
module tb_scaler_v;
    localparam int PS   = 128;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] scale_step_v;
    logic [7:0]  di_i;
    logic        de_i, hs_i, vs_i;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o;

    scaler_v #(.PIXEL_WIDTH(8), .PIXEL_STEP(PS), .COE_WIDTH(8), .MAX_LINE_WIDTH(MAXW)) dut (
        .clk(clk), .rst(rst), .scale_step_v(scale_step_v),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int pix   [16][16];
    int pcyc  [16][16];
    int hs_cyc[16];
    int mbuf  [MAXW];
    int vs_rise_drv, vs_fall_drv;

    int cap_d[$], cap_dc[$], cap_hc[$];
    int exp_d[$], exp_dc[$], exp_hc[$];
    int vs_rise_c, vs_fall_c;
    logic vs_o_q = 1'b0;

    always @(negedge clk) begin
        if (de_o) begin
            cap_d.push_back(int'(do_o));
            cap_dc.push_back(cyc);
        end
        if (hs_o) cap_hc.push_back(cyc);
        if (vs_o && !vs_o_q) vs_rise_c <= cyc;
        if (!vs_o && vs_o_q) vs_fall_c <= cyc;
        vs_o_q <= vs_o;
    end

    task automatic clear_caps();
        cap_d.delete(); cap_dc.delete(); cap_hc.delete();
        vs_rise_c = -1; vs_fall_c = -1;
    endtask

    task automatic fill(input int mode, input int nl, input int w);
        for (int l = 0; l < nl; l++)
            for (int x = 0; x < w; x++)
                pix[l][x] = (mode == 0) ? l * 10 : int'($urandom_range(0, 255));
    endtask

    task automatic drive_frame(input int step, input int nl, input int w, input int gap,
                               input int same, input int emask, input int vs_early);
        int wl, x;
        @(posedge clk); #1;
        scale_step_v = 16'(step); vs_i = 1'b1; vs_rise_drv = cyc;
        repeat (2) @(posedge clk);
        for (int l = 0; l < nl; l++) begin
            wl = emask[l] ? 0 : w;
            x  = 0;
            @(posedge clk); #1;
            hs_i = 1'b1; hs_cyc[l] = cyc;
            if (vs_early != 0 && l == nl - 1) begin
                vs_i = 1'b0; vs_fall_drv = cyc;
            end
            if (same != 0 && wl > 0) begin
                de_i = 1'b1; di_i = 8'(pix[l][0]); pcyc[l][0] = cyc; x = 1;
            end
            while (x < wl) begin
                @(posedge clk); #1;
                hs_i = 1'b0; de_i = 1'b1; di_i = 8'(pix[l][x]); pcyc[l][x] = cyc;
                x++;
                repeat (gap) begin
                    @(posedge clk); #1;
                    de_i = 1'b0;
                end
            end
            @(posedge clk); #1;
            hs_i = 1'b0; de_i = 1'b0;
            @(posedge clk); #1;
        end
        if (vs_early == 0) begin
            @(posedge clk); #1;
            vs_i = 1'b0; vs_fall_drv = cyc;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Output lines from the stored/current line pair, with pos advancing by step per emitted line
    task automatic model_frame(input int step, input int nl, input int w, input int emask);
        int st, pos, f, wl;
        bit emit;
        exp_d.delete(); exp_dc.delete(); exp_hc.delete();
        st  = (step < PS) ? PS : step;
        pos = 0;
        for (int l = 0; l < nl; l++) begin
            wl = emask[l] ? 0 : w;
            emit = 1'b0; f = 0;
            if (l > 0) begin
                if (pos < PS) begin
                    emit = 1'b1; f = pos; pos = pos + st - PS;
                end else begin
                    pos = pos - PS;
                end
            end
            if (emit) exp_hc.push_back(hs_cyc[l] + 3);
            for (int x = 0; x < wl && x < MAXW; x++) begin
                if (emit) begin
                    exp_d.push_back((mbuf[x] * (PS - f) + pix[l][x] * f + PS / 2) / PS);
                    exp_dc.push_back(pcyc[l][x] + 3);
                end
                mbuf[x] = pix[l][x];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scale_step_v = 16'd128; di_i = 8'd0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (do_o !== 8'd0 || de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: do=%0d de=%0b hs=%0b vs=%0b, expected all 0", do_o, de_o, hs_o, vs_o);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_ratios();
        int steps[5]   = '{128, 256, 192, 192, 129};
        int nls[5]     = '{3, 6, 5, 3, 3};
        int lastv[5]   = '{10, 40, 30, 1, 253};
        for (int t = 0; t < 5; t++) begin
            fill(0, nls[t], 4);
            if (t == 3) for (int x = 0; x < 4; x++) begin pix[0][x] = 5; pix[1][x] = 0; pix[2][x] = 1; end
            if (t == 4) for (int x = 0; x < 4; x++) begin pix[0][x] = 7; pix[1][x] = 255; pix[2][x] = 0; end
            clear_caps();
            drive_frame(steps[t], nls[t], 4, 0, 0, 0, 0);
            model_frame(steps[t], nls[t], 4, 0);
            checks++;
            if (cap_d.size() != exp_d.size()) begin
                errors++;
                $display("FAIL ratio%0d px_count: got %0d expected %0d", t, cap_d.size(), exp_d.size());
            end else begin
                for (int i = 0; i < exp_d.size(); i++) begin
                    checks++;
                    if (cap_d[i] !== exp_d[i] || cap_dc[i] !== exp_dc[i]) begin
                        errors++;
                        $display("FAIL ratio%0d px%0d: got %0d@%0d expected %0d@%0d", t, i, cap_d[i], cap_dc[i], exp_d[i], exp_dc[i]);
                    end
                end
            end
            checks++;
            if (cap_d.size() == 0 || cap_d[cap_d.size() - 1] !== lastv[t]) begin
                errors++;
                $display("FAIL ratio%0d last_px: got %0d expected %0d", t, (cap_d.size() == 0) ? -1 : cap_d[cap_d.size() - 1], lastv[t]);
            end
            checks++;
            if (cap_hc != exp_hc) begin
                errors++;
                $display("FAIL ratio%0d hs_o: got %0d pulses expected %0d", t, cap_hc.size(), exp_hc.size());
            end
            checks++;
            if (vs_rise_c !== vs_rise_drv + 3 || vs_fall_c !== vs_fall_drv + 3) begin
                errors++;
                $display("FAIL ratio%0d vs_o: got %0d/%0d expected %0d/%0d", t, vs_rise_c, vs_fall_c, vs_rise_drv + 3, vs_fall_drv + 3);
            end
        end
    endtask

    // gapped de_i, hs_i with de_i, empty line, over-width line, vs_i falling mid-line, clamped step
    task automatic test_boundaries();
        int steps[6] = '{128, 128, 192, 128, 256, 50};
        int nls[6]   = '{3, 4, 5, 4, 5, 4};
        int ws[6]    = '{4, 4, 4, 10, 4, 3};
        int gaps[6]  = '{1, 0, 0, 0, 1, 0};
        int sames[6] = '{0, 1, 0, 0, 1, 0};
        int ems[6]   = '{0, 0, 4, 0, 8, 0};
        int vse[6]   = '{0, 0, 0, 0, 1, 0};
        for (int t = 0; t < 6; t++) begin
            fill(1, nls[t], ws[t]);
            clear_caps();
            drive_frame(steps[t], nls[t], ws[t], gaps[t], sames[t], ems[t], vse[t]);
            model_frame(steps[t], nls[t], ws[t], ems[t]);
            checks++;
            if (cap_d.size() != exp_d.size()) begin
                errors++;
                $display("FAIL bound%0d px_count: got %0d expected %0d", t, cap_d.size(), exp_d.size());
            end else begin
                for (int i = 0; i < exp_d.size(); i++) begin
                    checks++;
                    if (cap_d[i] !== exp_d[i] || cap_dc[i] !== exp_dc[i]) begin
                        errors++;
                        $display("FAIL bound%0d px%0d: got %0d@%0d expected %0d@%0d", t, i, cap_d[i], cap_dc[i], exp_d[i], exp_dc[i]);
                    end
                end
            end
            checks++;
            if (cap_hc != exp_hc) begin
                errors++;
                $display("FAIL bound%0d hs_o: got %0d pulses expected %0d", t, cap_hc.size(), exp_hc.size());
            end
            checks++;
            if (vs_rise_c !== vs_rise_drv + 3 || vs_fall_c !== vs_fall_drv + 3) begin
                errors++;
                $display("FAIL bound%0d vs_o: got %0d/%0d expected %0d/%0d", t, vs_rise_c, vs_fall_c, vs_rise_drv + 3, vs_fall_drv + 3);
            end
        end
    endtask

    task automatic test_random();
        int step, nl, w, gap, same, em, vse;
        for (int t = 0; t < 8; t++) begin
            step = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 127)) : int'($urandom_range(128, 700));
            nl   = int'($urandom_range(3, 8));
            w    = int'($urandom_range(1, 10));
            gap  = int'($urandom_range(0, 1));
            same = int'($urandom_range(0, 1));
            em   = int'(($urandom_range(0, 255) & $urandom_range(0, 255)) << 1) & ((1 << nl) - 1);
            vse  = int'($urandom_range(0, 3) == 0);
            fill(1, nl, w);
            clear_caps();
            drive_frame(step, nl, w, gap, same, em, vse);
            model_frame(step, nl, w, em);
            checks++;
            if (cap_d.size() != exp_d.size()) begin
                errors++;
                $display("FAIL rand%0d px_count (step %0d): got %0d expected %0d", t, step, cap_d.size(), exp_d.size());
            end else begin
                for (int i = 0; i < exp_d.size(); i++) begin
                    checks++;
                    if (cap_d[i] !== exp_d[i] || cap_dc[i] !== exp_dc[i]) begin
                        errors++;
                        $display("FAIL rand%0d px%0d: got %0d@%0d expected %0d@%0d", t, i, cap_d[i], cap_dc[i], exp_d[i], exp_dc[i]);
                    end
                end
            end
            checks++;
            if (cap_hc != exp_hc) begin
                errors++;
                $display("FAIL rand%0d hs_o: got %0d pulses expected %0d", t, cap_hc.size(), exp_hc.size());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int budget;
        @(posedge clk); #1;
        scale_step_v = 16'd128; vs_i = 1'b1;
        for (int l = 0; l < 2; l++) begin
            @(posedge clk); #1;
            hs_i = 1'b1;
            for (int x = 0; x < 6; x++) begin
                @(posedge clk); #1;
                hs_i = 1'b0; de_i = 1'b1; di_i = 8'(l * 10 + 3);
            end
            if (l == 0) begin
                @(posedge clk); #1;
                de_i = 1'b0;
            end
        end
        budget = 0;
        while (de_o !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (de_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid pre_de_o: got %0b expected 1 within 20 cycles", de_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (do_o !== 8'd0 || de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid outputs: do=%0d de=%0b hs=%0b vs=%0b, expected all 0", do_o, de_o, hs_o, vs_o);
        end
        de_i = 1'b0; hs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 vs_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        fill(0, 3, 4);
        clear_caps();
        drive_frame(128, 3, 4, 0, 0, 0, 0);
        model_frame(128, 3, 4, 0);
        checks++;
        if (cap_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL rstmid px_count: got %0d expected %0d", cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                checks++;
                if (cap_d[i] !== exp_d[i] || cap_dc[i] !== exp_dc[i]) begin
                    errors++;
                    $display("FAIL rstmid px%0d: got %0d@%0d expected %0d@%0d", i, cap_d[i], cap_dc[i], exp_d[i], exp_dc[i]);
                end
            end
        end
        checks++;
        if (cap_hc != exp_hc) begin
            errors++;
            $display("FAIL rstmid hs_o: got %0d pulses expected %0d", cap_hc.size(), exp_hc.size());
        end
    endtask

    initial begin
        test_reset();
        test_ratios();
        test_boundaries();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
